// File: rtl/seq_div_32_pkg.sv
// Shared definitions for the sequential 32-bit divider: FSM encoding, step count
// and two's-complement helpers.
package seq_div_32_pkg;

  localparam int DIV_CYCLES = 32;
  localparam int CNT_W      = $clog2(DIV_CYCLES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  typedef struct packed {
    logic dvd_neg;
    logic dvs_neg;
    logic dvs_zero;
  } op_flags_t;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  function automatic logic [31:0] cond_neg(input logic [31:0] x, input logic n);
    return n ? neg32(x) : x;
  endfunction

endpackage

// File: rtl/seq_div_32_addsub.sv
// 32-bit adder/subtractor; in subtract mode cout_o=1 means no borrow (a_i >= b_i).
// Purely combinational.
module seq_div_32_addsub (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        sub_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  logic [31:0] b_eff;
  logic [32:0] full;

  assign b_eff  = sub_i ? ~b_i : b_i;
  assign full   = {1'b0, a_i} + {1'b0, b_eff} + {32'd0, sub_i};
  assign sum_o  = full[31:0];
  assign cout_o = full[32];

endmodule

// File: rtl/seq_div_32.sv
// Sequential restoring divider: one quotient bit per clock, 33-cycle latency,
// divide-by-zero short-circuits to a 1-cycle result with div_zero flagged.
module seq_div_32
  import seq_div_32_pkg::*;
#(
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sign,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        ready,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        div_zero
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      quo_q, quo_d;
  logic [31:0]      rem_q, rem_d;
  logic [31:0]      dvs_q, dvs_d;
  op_flags_t        flags_q, flags_d;
  logic [31:0]      q_q, q_d;
  logic [31:0]      r_q, r_d;
  logic             dz_q, dz_d;
  logic             ready_q, ready_d;

  logic        signed_mode;
  logic        in_dvd_neg;
  logic        in_dvs_neg;
  logic        in_dvs_zero;
  logic [31:0] trial;
  logic [31:0] diff;
  logic        no_borrow;

  assign signed_mode = SIGNED_EN && sign;
  assign in_dvd_neg  = signed_mode && dividend[31];
  assign in_dvs_neg  = signed_mode && divisor[31];
  assign in_dvs_zero = (divisor == 32'd0);

  // quo_q starts as |dividend| and shifts left; freed low bits collect quotient bits.
  assign trial = {rem_q[30:0], quo_q[31]};

  seq_div_32_addsub u_sub (
    .a_i    (trial),
    .b_i    (dvs_q),
    .sub_i  (1'b1),
    .sum_o  (diff),
    .cout_o (no_borrow)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    flags_d = flags_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    ready_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          flags_d.dvd_neg  = in_dvd_neg;
          flags_d.dvs_neg  = in_dvs_neg;
          flags_d.dvs_zero = in_dvs_zero;
          quo_d   = cond_neg(dividend, in_dvd_neg);
          dvs_d   = cond_neg(divisor, in_dvs_neg);
          // Zero divisor reports the raw dividend, so park it in the remainder.
          rem_d   = in_dvs_zero ? dividend : 32'd0;
          cnt_d   = '0;
          dz_d    = 1'b0;
          state_d = in_dvs_zero ? ST_FIX : ST_CALC;
        end
      end

      ST_CALC: begin
        rem_d = no_borrow ? diff : trial;
        quo_d = {quo_q[30:0], no_borrow};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        if (flags_q.dvs_zero) begin
          q_d  = 32'hFFFF_FFFF;
          r_d  = rem_q;
          dz_d = 1'b1;
        end else begin
          q_d  = cond_neg(quo_q, flags_q.dvd_neg ^ flags_q.dvs_neg);
          r_d  = cond_neg(rem_q, flags_q.dvd_neg);
          dz_d = 1'b0;
        end
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      flags_q <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      flags_q <= flags_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      ready_q <= ready_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign ready    = ready_q;
  assign q        = q_q;
  assign r        = r_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_seq_div_32.sv
// Scoreboard bench for seq_div_32: directed corner cases plus random operands
// checked against an arithmetic reference model.
module tb_seq_div_32;

  localparam bit TB_SIGNED_EN = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sign;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        ready;
  logic [31:0] q;
  logic [31:0] r;
  logic        div_zero;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
    longint      t0;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  seq_div_32 #(.SIGNED_EN(TB_SIGNED_EN)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sign     (sign),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .ready    (ready),
    .q        (q),
    .r        (r),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic exp_t model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sd;
    e.t0 = 0;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1; e.lat = 1;
    end else begin
      if (sgn && TB_SIGNED_EN) begin
        sa = longint'($signed(a));
        sd = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sd = longint'({32'd0, b});
      end
      e.q = 32'(sa / sd);
      e.r = 32'(sa % sd);
      e.dz = 1'b0; e.lat = 33;
    end
    return e;
  endfunction

  // Waits for IDLE, presents one request for a single edge and books the expectation.
  task automatic issue(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) fail_now("issue_wait_idle");
    sign = sgn; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    e = model(sgn, a, b);
    e.t0 = $time;
    sb.push_back(e);
    #1 start = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) fail_now("wait_ready");
  endtask

  // Monitor: every ready pulse must match the oldest booked expectation.
  always @(negedge clk) begin
    if (!rst && ready) begin
      if (sb.size() == 0) begin
        fail_now("unexpected_ready");
      end else begin
        exp_t   e;
        longint lat;
        e   = sb.pop_front();
        lat = ($time - e.t0 - 5) / 10;
        chk("q", q, e.q);
        chk("r", r, e.r);
        chk("div_zero", 32'(div_zero), 32'(e.dz));
        chk("busy_at_ready", 32'(busy), 32'd0);
        chk("latency", 32'(lat), 32'(e.lat));
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; sign = 1'b0; dividend = '0; divisor = '0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_q", q, 32'd0);
    chk("rst_r", r, 32'd0);
    chk("rst_dz", 32'(div_zero), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    issue(1'b0, 32'd100, 32'd7);
    issue(1'b1, -32'sd7, 32'd2);
    issue(1'b1, 32'd7, -32'sd2);
    issue(1'b0, 32'd5, 32'd0);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(1'b0, 32'hFFFF_FFFF, 32'd1);
    issue(1'b0, 32'hFFFF_FFFF, 32'hC000_0000);

    // Start while busy must be ignored; start during the ready cycle must be taken.
    issue(1'b0, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    dividend = 32'd50; divisor = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_ready();
    issue(1'b0, 32'd200, 32'd9);

    // Reset mid-division: outputs clear at once and no result emerges.
    issue(1'b1, -32'sd1000, 32'd13);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd0);
    chk("midrst_q", q, 32'd0);
    chk("midrst_r", r, 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (ready) seen++;
      end
      chk("no_ready_after_rst", 32'(seen), 32'd0);
    end
    issue(1'b0, 32'd100, 32'd7);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      bit          sg;
      a  = $urandom;
      sg = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = $urandom_range(1, 255);
        2:       b = -$urandom_range(1, 16);
        default: b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom_range(1, 65535);
      endcase
      issue(sg, a, b);
    end

    begin
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (sb.size() != 0) fail_now("drain_scoreboard");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_div_32.md
SEQ_DIV_32 -- requirements
Module: seq_div_32

Interface
REQ-001 SHALL have parameter SIGNED_EN, default 1; 1 enables signed mode via the sign input, 0 forces unsigned operation.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1, request a division; sampled only in IDLE.
REQ-005 SHALL have port sign, input, 1, 1 = two's-complement operands; ignored when SIGNED_EN=0.
REQ-006 SHALL have port dividend, input, 32, numerator; sampled only at the accepting edge.
REQ-007 SHALL have port divisor, input, 32, denominator; sampled only at the accepting edge.
REQ-008 SHALL have port busy, output, 1, high while a division is in progress.
REQ-009 SHALL have port ready, output, 1, one-cycle pulse marking valid q/r.
REQ-010 SHALL have port q, output, 32, quotient.
REQ-011 SHALL have port r, output, 32, remainder.
REQ-012 SHALL have port div_zero, output, 1, high with ready when divisor was 0; held until the next accepted start.

Function
REQ-013 SHALL use FSM states IDLE, CALC, FIX.
REQ-014 SHALL accept at edge E0 when state=IDLE and start=1: latch |dividend| and |divisor| (absolute values only in signed mode), latch both operand sign bits, clear iteration counter, go to CALC.
REQ-015 SHALL, in CALC, run restoring division with one quotient bit per edge, MSB first.
REQ-016 SHALL, per CALC step, trial-subtract divisor from {partial_rem[30:0], next dividend bit}; no borrow (carry-out=1) keeps the difference and sets the quotient bit to 1; otherwise restore and set it to 0.
REQ-017 SHALL execute CALC at edges E1..E32; the counter wraps 31->0 and moves to FIX after the 32nd step.
REQ-018 SHALL, at E33 (FIX), register q (negated if operand signs differ), r (negated if dividend was negative), and div_zero=0, assert ready, go to IDLE.
REQ-019 SHALL hold busy=1 from E0 to E33 and ready=1 only between E33 and E34; latency is 33 cycles.
REQ-020 SHALL, when divisor=0 at accept, skip CALC and go to FIX; at E1 register q=32'hFFFFFFFF, r=dividend (raw), div_zero=1, ready=1.
REQ-021 SHALL compute signed 0x80000000 / 0xFFFFFFFF as q=0x80000000, r=0 with no flag.
REQ-022 SHALL ignore start while busy; operands are not re-sampled.
REQ-023 SHALL accept a start asserted in the same cycle as ready, since state is IDLE then.
REQ-024 SHALL hold q, r, and div_zero stable from ready until the next FIX write.

Reset
REQ-025 SHALL, on rst=1 at any time including mid-CALC, force IDLE, clear the counter, and set busy=0, ready=0, q=0, r=0, div_zero=0 without waiting for a clock edge.
REQ-026 SHALL resume normal operation at the first rising edge after rst deasserts; no partial result is ever emitted.

Structure
REQ-027 SHALL take the FSM state encoding and constant DIV_CYCLES=32 from the shared CPU package.
REQ-028 SHALL perform the trial subtraction with one ADDSUB_32 instance (Sub=1), using its carry-out as the no-borrow indicator.
REQ-029 SHALL perform absolute-value and sign-fix negation as 32-bit two's-complement arithmetic; no second divider datapath.

Verification
REQ-030 SHALL cover: unsigned 100/7 -> q=14, r=2, ready pulse exactly 33 cycles after accept, busy low afterward.
REQ-031 SHALL cover: signed -7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF; signed 7/-2 -> q=0xFFFFFFFD, r=1.
REQ-032 SHALL cover: 5/0 -> q=0xFFFFFFFF, r=5, div_zero=1, ready one cycle after accept.
REQ-033 SHALL cover: signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0; unsigned 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
REQ-034 SHALL cover: start with new operands at cycle 10 of a busy 100/7 -> ignored, result still 14/2; start in the ready cycle -> accepted.
REQ-035 SHALL cover: rst pulse at cycle 15 of a division -> busy, ready, q, r all 0 immediately; no ready pulse follows; the next division completes correctly.
